// File: rtl/mlp_layer_sequencer.sv
// Control sequencer for the shared MAC datapath of a two-layer MLP.
// Walks every neuron of both layers: clear, accumulate, bias, drain, write back.
module mlp_layer_sequencer #(
    parameter int N_IN    = 4,
    parameter int N_HID   = 10,
    parameter int N_OUT   = 2,
    parameter int MAC_LAT = 2,
    parameter int AW      = 8,
    parameter int XW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          mac_bias,
    output logic [AW-1:0] w_addr,
    output logic [XW-1:0] x_addr,
    output logic          x_sel,
    output logic          wb_en,
    output logic          wb_layer,
    output logic [XW-1:0] wb_idx
);
    localparam int B1       = N_HID * (N_IN + 1);
    localparam int MAX_ADDR = B1 + N_OUT * (N_HID + 1) - 1;
    localparam int DW       = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [AW-1:0] B1_A  = AW'(B1);
    localparam logic [AW-1:0] F0_A  = AW'(N_IN);
    localparam logic [AW-1:0] F1_A  = AW'(N_HID);
    localparam logic [AW-1:0] F0P_A = AW'(N_IN + 1);
    localparam logic [AW-1:0] F1P_A = AW'(N_HID + 1);
    localparam logic [XW-1:0] K0_LAST = XW'(N_IN - 1);
    localparam logic [XW-1:0] K1_LAST = XW'(N_HID - 1);
    localparam logic [XW-1:0] N0_LAST = XW'(N_HID - 1);
    localparam logic [XW-1:0] N1_LAST = XW'(N_OUT - 1);
    localparam logic [DW-1:0] D_LAST  = (MAC_LAT > 0) ? DW'(MAC_LAT - 1) : '0;

    if (MAX_ADDR >= (2 ** AW) || N_IN > (2 ** XW) || N_HID > (2 ** XW) ||
        N_OUT > (2 ** XW) || N_IN < 1 || N_HID < 1 || N_OUT < 1 || MAC_LAT < 0) begin : g_param_err
        $error("mlp_layer_sequencer: parameters do not fit AW/XW");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_CLR, S_ACC, S_BIAS, S_DRAIN, S_WB, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic          layer_q, layer_d;
    logic [XW-1:0] n_q, n_d, k_q, k_d;
    logic [DW-1:0] d_q, d_d;

    logic          busy_q, busy_d, done_q, done_d;
    logic          mac_clr_q, mac_clr_d, mac_en_q, mac_en_d, mac_bias_q, mac_bias_d;
    logic [AW-1:0] w_addr_q, w_addr_d, row_d;
    logic [XW-1:0] x_addr_q, x_addr_d, wb_idx_q, wb_idx_d;
    logic          x_sel_q, x_sel_d, wb_en_q, wb_en_d, wb_layer_q, wb_layer_d;

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        n_d     = n_q;
        k_d     = k_q;
        d_d     = d_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_CLR;
                layer_d = 1'b0;
                n_d     = '0;
            end
            S_CLR: begin
                k_d     = '0;
                state_d = S_ACC;
            end
            S_ACC: begin
                if (k_q == (layer_q ? K1_LAST : K0_LAST)) state_d = S_BIAS;
                else k_d = k_q + XW'(1);
            end
            S_BIAS: begin
                d_d     = '0;
                state_d = (MAC_LAT > 0) ? S_DRAIN : S_WB;
            end
            S_DRAIN: begin
                if (d_q == D_LAST) state_d = S_WB;
                else d_d = d_q + DW'(1);
            end
            S_WB: begin
                if (n_q != (layer_q ? N1_LAST : N0_LAST)) begin
                    n_d     = n_q + XW'(1);
                    state_d = S_CLR;
                end else if (!layer_q) begin
                    layer_d = 1'b1;
                    n_d     = '0;
                    state_d = S_CLR;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        row_d      = (layer_d ? B1_A : '0) + AW'(n_d) * (layer_d ? F1P_A : F0P_A);
        busy_d     = state_d inside {S_CLR, S_ACC, S_BIAS, S_DRAIN, S_WB};
        done_d     = (state_d == S_DONE);
        mac_clr_d  = (state_d == S_CLR);
        mac_en_d   = (state_d == S_ACC) || (state_d == S_BIAS);
        mac_bias_d = (state_d == S_BIAS);
        x_sel_d    = mac_en_d && layer_d;
        x_addr_d   = (state_d == S_ACC) ? k_d : '0;
        wb_en_d    = (state_d == S_WB);
        wb_layer_d = wb_en_d && layer_d;
        wb_idx_d   = wb_en_d ? n_d : '0;
        case (state_d)
            S_ACC:   w_addr_d = row_d + AW'(k_d);
            S_BIAS:  w_addr_d = row_d + (layer_d ? F1_A : F0_A);
            default: w_addr_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            layer_q    <= 1'b0;
            n_q        <= '0;
            k_q        <= '0;
            d_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_bias_q <= 1'b0;
            w_addr_q   <= '0;
            x_addr_q   <= '0;
            x_sel_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_layer_q <= 1'b0;
            wb_idx_q   <= '0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            n_q        <= n_d;
            k_q        <= k_d;
            d_q        <= d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mac_clr_q  <= mac_clr_d;
            mac_en_q   <= mac_en_d;
            mac_bias_q <= mac_bias_d;
            w_addr_q   <= w_addr_d;
            x_addr_q   <= x_addr_d;
            x_sel_q    <= x_sel_d;
            wb_en_q    <= wb_en_d;
            wb_layer_q <= wb_layer_d;
            wb_idx_q   <= wb_idx_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign mac_clr  = mac_clr_q;
    assign mac_en   = mac_en_q;
    assign mac_bias = mac_bias_q;
    assign w_addr   = w_addr_q;
    assign x_addr   = x_addr_q;
    assign x_sel    = x_sel_q;
    assign wb_en    = wb_en_q;
    assign wb_layer = wb_layer_q;
    assign wb_idx   = wb_idx_q;
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Bench: two sequencer configurations checked cycle by cycle against a
// trace built from nested layer/neuron/input loops.
module tb_mlp_layer_sequencer;
    localparam int AW = 8;
    localparam int XW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, start;
    logic [1:0] busy, done, mac_clr, mac_en, mac_bias, x_sel, wb_en, wb_layer;
    logic [AW-1:0] w_addr [2];
    logic [XW-1:0] x_addr [2];
    logic [XW-1:0] wb_idx [2];

    mlp_layer_sequencer #(.N_IN(4), .N_HID(10), .N_OUT(2), .MAC_LAT(2), .AW(AW), .XW(XW)) u_def (
        .clk(clk), .rst(rst[0]), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .mac_clr(mac_clr[0]), .mac_en(mac_en[0]), .mac_bias(mac_bias[0]), .w_addr(w_addr[0]),
        .x_addr(x_addr[0]), .x_sel(x_sel[0]), .wb_en(wb_en[0]), .wb_layer(wb_layer[0]),
        .wb_idx(wb_idx[0]));

    mlp_layer_sequencer #(.N_IN(1), .N_HID(1), .N_OUT(1), .MAC_LAT(0), .AW(AW), .XW(XW)) u_small (
        .clk(clk), .rst(rst[1]), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .mac_clr(mac_clr[1]), .mac_en(mac_en[1]), .mac_bias(mac_bias[1]), .w_addr(w_addr[1]),
        .x_addr(x_addr[1]), .x_sel(x_sel[1]), .wb_en(wb_en[1]), .wb_layer(wb_layer[1]),
        .wb_idx(wb_idx[1]));

    typedef struct packed {
        logic          busy, done, clr, en, bias;
        logic [AW-1:0] w;
        logic [XW-1:0] x;
        logic          xs, wb, wl;
        logic [XW-1:0] wi;
    } vec_t;

    int   n_chk = 0, n_fail = 0, cyc = 0;
    vec_t q0[$], q1[$];
    vec_t cur [2];
    int   rd_cnt [256];

    function automatic int p_in(int i);  return i ? 1 : 4;  endfunction
    function automatic int p_hid(int i); return i ? 1 : 10; endfunction
    function automatic int p_out(int i); return i ? 1 : 2;  endfunction
    function automatic int p_lat(int i); return i ? 0 : 2;  endfunction

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic vec_t dut_vec(int i);
        vec_t v;
        v.busy = busy[i]; v.done = done[i]; v.clr = mac_clr[i]; v.en = mac_en[i];
        v.bias = mac_bias[i]; v.w = w_addr[i]; v.x = x_addr[i]; v.xs = x_sel[i];
        v.wb = wb_en[i]; v.wl = wb_layer[i]; v.wi = wb_idx[i];
        return v;
    endfunction

    task automatic push(input int i, input vec_t v);
        if (i == 0) q0.push_back(v); else q1.push_back(v);
    endtask

    // Expected output for every cycle of one complete run, from CLR to DONE.
    task automatic gen(input int i);
        vec_t v;
        int f, nn, b;
        for (int l = 0; l < 2; l++) begin
            f  = l ? p_hid(i) : p_in(i);
            nn = l ? p_out(i) : p_hid(i);
            b  = l ? p_hid(i) * (p_in(i) + 1) : 0;
            for (int n = 0; n < nn; n++) begin
                v = '0; v.busy = 1; v.clr = 1; push(i, v);
                for (int k = 0; k < f; k++) begin
                    v = '0; v.busy = 1; v.en = 1; v.w = AW'(b + n * (f + 1) + k);
                    v.x = XW'(k); v.xs = l[0]; push(i, v);
                end
                v = '0; v.busy = 1; v.en = 1; v.bias = 1; v.w = AW'(b + n * (f + 1) + f);
                v.xs = l[0]; push(i, v);
                for (int d = 0; d < p_lat(i); d++) begin
                    v = '0; v.busy = 1; push(i, v);
                end
                v = '0; v.busy = 1; v.wb = 1; v.wl = l[0]; v.wi = XW'(n); push(i, v);
            end
        end
        v = '0; v.done = 1; push(i, v);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                cur[i] = '0;
                if (i == 0) q0.delete(); else q1.delete();
            end else if ((i == 0 ? q0.size() : q1.size()) != 0) begin
                cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
            end else if (!cur[i].busy && !cur[i].done && start[i]) begin
                gen(i);
                cur[i] = (i == 0) ? q0.pop_front() : q1.pop_front();
            end else begin
                cur[i] = '0;
            end
        end
    end

    always @(negedge clk) begin
        int bad;
        for (int i = 0; i < 2; i++) begin
            check("outputs", i, 32'(dut_vec(i)), 32'(cur[i]));
            check("strobe_excl", i, 32'(int'(mac_clr[i]) + int'(mac_en[i]) + int'(wb_en[i]) <= 1), 32'd1);
        end
        if (!cur[0].busy && !cur[0].done) begin
            for (int a = 0; a < 256; a++) rd_cnt[a] = 0;
        end else begin
            if (mac_en[0]) rd_cnt[w_addr[0]]++;
            if (cur[0].done) begin
                bad = 0;
                for (int a = 0; a < 72; a++) if (rd_cnt[a] != 1) bad++;
                for (int a = 72; a < 256; a++) if (rd_cnt[a] != 0) bad++;
                check("addr_once", 0, 32'(bad), 32'd0);
            end
        end
    end

    int done_at [2], done_n [2];
    int clr123;

    // Runs a window of len cycles after a start pulse; records done timing per instance.
    task automatic window(input int len, input int s_from, input int s_to, input int rst_at, input bit hold);
        for (int i = 0; i < 2; i++) begin done_at[i] = 0; done_n[i] = 0; end
        clr123 = 0;
        @(negedge clk); start = 2'b11;
        for (int t = 1; t <= len; t++) begin
            @(negedge clk);
            start = (hold || (t >= s_from && t <= s_to)) ? 2'b11 : 2'b00;
            rst   = (t == rst_at) ? 2'b11 : 2'b00;
            if (t == 1) check("busy_c1", 0, 32'(busy[0]), 32'd1);
            if (t == 123 && mac_clr[0]) clr123 = 1;
            for (int i = 0; i < 2; i++) if (done[i]) begin
                done_n[i]++;
                if (done_at[i] == 0) done_at[i] = t;
            end
        end
        start = 2'b00; rst = 2'b00;
    endtask

    initial begin
        rst = 2'b11; start = 2'b00;
        cur[0] = '0; cur[1] = '0;
        gen(0); gen(1);
        check("pin_len", 0, 32'(q0.size()), 32'd121);
        check("pin_w5", 0, 32'(q0[4].w), 32'd3);
        check("pin_bias6", 0, {q0[5].bias, 7'(q0[5].w)}, {1'b1, 7'd4});
        check("pin_wb9", 0, {q0[8].wb, q0[8].wl, 4'(q0[8].wi)}, 6'b10_0000);
        check("pin_wb90", 0, {q0[89].wb, 4'(q0[89].wi)}, 5'b1_1001);
        check("pin_l2acc", 0, {q0[91].xs, 8'(q0[91].w)}, {1'b1, 8'd50});
        check("pin_l2bias", 0, 32'(q0[101].w), 32'd60);
        check("pin_n1acc", 0, 32'(q0[106].w), 32'd61);
        check("pin_n1bias", 0, 32'(q0[116].w), 32'd71);
        check("pin_wb105", 0, {q0[104].wb, q0[104].wl, 4'(q0[104].wi)}, 6'b11_0000);
        check("pin_wb120", 0, {q0[119].wb, q0[119].wl, 4'(q0[119].wi)}, 6'b11_0001);
        check("pin_done", 0, {q0[120].done, q0[120].busy}, 2'b10);
        check("pin_s_len", 1, 32'(q1.size()), 32'd9);
        check("pin_s_wb", 1, {q1[3].wb, q1[7].wb, q1[7].wl, q1[8].done}, 4'b1111);
        check("pin_s_w", 1, {8'(q1[2].w), 8'(q1[5].w), 8'(q1[6].w)}, {8'd1, 8'd2, 8'd3});
        q0.delete(); q1.delete();

        repeat (3) @(negedge clk);
        rst = 2'b00;
        repeat (2) @(negedge clk);

        window(140, 0, -1, -1, 0);
        check("done_cyc", 0, 32'(done_at[0]), 32'd121);
        check("done_cyc", 1, 32'(done_at[1]), 32'd9);
        check("done_once", 0, 32'(done_n[0]), 32'd1);

        window(140, 10, 50, -1, 0);
        check("ign_done_cyc", 0, 32'(done_at[0]), 32'd121);
        check("ign_done_once", 0, 32'(done_n[0]), 32'd1);

        window(260, 0, -1, -1, 1);
        check("hold_clr123", 0, 32'(clr123), 32'd1);
        check("hold_done2", 0, 32'(done_n[0]), 32'd2);
        repeat (130) @(negedge clk);

        window(200, 0, -1, 40, 0);
        check("rst_no_done", 0, 32'(done_n[0]), 32'd0);
        check("rst_idle", 0, 32'(busy[0]), 32'd0);

        window(130, 0, -1, -1, 0);
        check("restart_done", 0, 32'(done_at[0]), 32'd121);

        for (int t = 0; t < 4000; t++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                start[i] = ($urandom_range(0, 9) == 0);
                rst[i]   = ($urandom_range(0, 399) == 0);
            end
        end
        start = 2'b00; rst = 2'b00;
        repeat (150) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
